// File: rtl/cube_field_generator_if.sv
// Pixel, landing and status signals between the VGA/game logic and the cube field.
interface cube_field_generator_if #(
    parameter int unsigned ROWS = 4
);
    localparam int unsigned NCUBES = ROWS * (ROWS + 1) / 2;
    localparam int unsigned IDX_W  = (NCUBES > 1) ? $clog2(NCUBES) : 1;
    localparam int unsigned CNT_W  = $clog2(NCUBES + 1);

    logic [10:0]      x_cnt;
    logic [9:0]       y_cnt;
    logic [10:0]      x_offset;
    logic [9:0]       y_offset;
    logic [10:0]      qbert_x;
    logic [9:0]       qbert_y;
    logic             qbert_land;
    logic             level_clear;
    logic             top_face;
    logic             left_face;
    logic             right_face;
    logic             top_visited;
    logic [IDX_W-1:0] cube_idx;
    logic             land_ack;
    logic             fall;
    logic [CNT_W-1:0] visited_count;
    logic             level_done;

    modport master (
        output x_cnt, y_cnt, x_offset, y_offset, qbert_x, qbert_y, qbert_land, level_clear,
        input  top_face, left_face, right_face, top_visited, cube_idx,
               land_ack, fall, visited_count, level_done
    );

    modport slave (
        input  x_cnt, y_cnt, x_offset, y_offset, qbert_x, qbert_y, qbert_land, level_clear,
        output top_face, left_face, right_face, top_visited, cube_idx,
               land_ack, fall, visited_count, level_done
    );
endinterface

// File: rtl/cube_field_generator.sv
// Q*bert pyramid renderer: 2-stage per-pixel face classification for every cube,
// plus a landing FSM that tracks visited cubes and level completion.
module cube_field_generator #(
    parameter int unsigned XHALF = 50,
    parameter int unsigned YHALF = 30,
    parameter int unsigned DEPTH = 60,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned MODE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    cube_field_generator_if.slave bus
);
    localparam int unsigned NCUBES = ROWS * (ROWS + 1) / 2;
    localparam int unsigned IDX_W  = (NCUBES > 1) ? $clog2(NCUBES) : 1;
    localparam int unsigned CNT_W  = $clog2(NCUBES + 1);
    localparam int unsigned CW     = 13;
    localparam int unsigned PW     = 26;
    localparam logic signed [PW-1:0] XY_S   = PW'(XHALF * YHALF);
    localparam logic signed [PW-1:0] SIDE_S = PW'(DEPTH * XHALF);
    localparam logic signed [CW-1:0] XH_S   = CW'(XHALF);

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, COMPLETE} state_e;

    function automatic int idx_of(input int r, input int c);
        return r * (r + 1) / 2 + c;
    endfunction

    logic signed [CW-1:0] cx_c [NCUBES];
    logic signed [CW-1:0] cy_c [NCUBES];
    logic [PW-1:0]        pa_d [NCUBES];
    logic [PW-1:0]        pb_d [NCUBES];
    logic [PW-1:0]        pa_q [NCUBES];
    logic [PW-1:0]        pb_q [NCUBES];
    logic [NCUBES-1:0]    dxn_d, dyn_d, dxl_d, dxr_d;
    logic [NCUBES-1:0]    dxn_q, dyn_q, dxl_q, dxr_q;
    logic [NCUBES-1:0]    top_c, left_c, right_c;

    // Per-cube centre, distance and product terms (stage 1) and face tests (stage 2).
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c <= r; c++) begin : g_col
            localparam int unsigned IDX = r * (r + 1) / 2 + c;
            localparam logic signed [CW-1:0] XOFF = CW'((2 * c - r) * int'(XHALF));
            localparam logic signed [CW-1:0] YOFF = CW'(r * int'(YHALF + DEPTH));
            logic signed [CW-1:0] dx, dy, adx, ady;
            logic signed [PW-1:0] thr, dyx;
            logic                 side;

            assign cx_c[IDX]  = $signed({2'b00, bus.x_offset}) + XOFF;
            assign cy_c[IDX]  = $signed({3'b000, bus.y_offset}) + YOFF;
            assign dx         = $signed({2'b00, bus.x_cnt}) - cx_c[IDX];
            assign dy         = $signed({3'b000, bus.y_cnt}) - cy_c[IDX];
            assign adx        = dx[CW-1] ? -dx : dx;
            assign ady        = dy[CW-1] ? -dy : dy;
            assign pa_d[IDX]  = PW'($unsigned(adx)) * PW'(YHALF);
            assign pb_d[IDX]  = PW'($unsigned(ady)) * PW'(XHALF);
            assign dxn_d[IDX] = dx[CW-1];
            assign dyn_d[IDX] = dy[CW-1];
            assign dxl_d[IDX] = (dx >= -XH_S);
            assign dxr_d[IDX] = (dx < XH_S);

            assign thr  = XY_S - $signed(pa_q[IDX]);
            assign dyx  = dyn_q[IDX] ? -$signed(pb_q[IDX]) : $signed(pb_q[IDX]);
            assign side = (thr < dyx) && (dyx <= thr + SIDE_S);
            assign top_c[IDX]   = (pa_q[IDX] + pb_q[IDX]) <= $unsigned(XY_S);
            assign left_c[IDX]  = !top_c[IDX] && dxn_q[IDX] && dxl_q[IDX] && side;
            assign right_c[IDX] = !top_c[IDX] && !dxn_q[IDX] && dxr_q[IDX] && side;
        end
    end

    // Stage 1 register: products and sign/range flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCUBES; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
            dxn_q <= '0;
            dyn_q <= '0;
            dxl_q <= '0;
            dxr_q <= '0;
        end else begin
            for (int i = 0; i < NCUBES; i++) begin
                pa_q[i] <= pa_d[i];
                pb_q[i] <= pb_d[i];
            end
            dxn_q <= dxn_d;
            dyn_q <= dyn_d;
            dxl_q <= dxl_d;
            dxr_q <= dxr_d;
        end
    end

    logic [NCUBES-1:0] visited_q, visited_d;
    logic              win_top, win_left, win_right, win_vis;
    logic [IDX_W-1:0]  win_idx;

    // Front cube wins: scan rows upward, columns right-to-left, last hit kept.
    always_comb begin
        win_top   = 1'b0;
        win_left  = 1'b0;
        win_right = 1'b0;
        win_vis   = 1'b0;
        win_idx   = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = r; c >= 0; c--) begin
                if (top_c[idx_of(r, c)] || left_c[idx_of(r, c)] || right_c[idx_of(r, c)]) begin
                    win_top   = top_c[idx_of(r, c)];
                    win_left  = left_c[idx_of(r, c)];
                    win_right = right_c[idx_of(r, c)];
                    win_vis   = visited_q[idx_of(r, c)];
                    win_idx   = IDX_W'(idx_of(r, c));
                end
            end
        end
    end

    logic             top_q, left_q, right_q, vis_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            vis_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            top_q   <= win_top;
            left_q  <= win_left;
            right_q <= win_right;
            vis_q   <= win_vis;
            idx_q   <= win_idx;
        end
    end

    state_e           state_q, state_d;
    logic [10:0]      qx_q, qx_d;
    logic [9:0]       qy_q, qy_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hidx_q, hidx_d;
    logic             ack_q, ack_d, fall_q, fall_d, done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            qx_q      <= '0;
            qy_q      <= '0;
            hit_q     <= 1'b0;
            hidx_q    <= '0;
            ack_q     <= 1'b0;
            fall_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            visited_q <= '0;
        end else begin
            state_q   <= state_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            hit_q     <= hit_d;
            hidx_q    <= hidx_d;
            ack_q     <= ack_d;
            fall_q    <= fall_d;
            done_q    <= done_d;
            count_q   <= count_d;
            visited_q <= visited_d;
        end
    end

    // Landing FSM; ack/fall are decided in LOOKUP so they show during UPDATE.
    always_comb begin
        state_d   = state_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        hit_d     = hit_q;
        hidx_d    = hidx_q;
        ack_d     = 1'b0;
        fall_d    = 1'b0;
        done_d    = done_q;
        count_d   = count_q;
        visited_d = visited_q;
        case (state_q)
            IDLE: begin
                if (bus.qbert_land) begin
                    qx_d    = bus.qbert_x;
                    qy_d    = bus.qbert_y;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d  = 1'b0;
                hidx_d = '0;
                for (int i = 0; i < NCUBES; i++) begin
                    if (cx_c[i] == $signed({2'b00, qx_q}) && cy_c[i] == $signed({3'b000, qy_q})) begin
                        hit_d  = 1'b1;
                        hidx_d = IDX_W'(i);
                    end
                end
                ack_d   = hit_d;
                fall_d  = !hit_d;
                state_d = UPDATE;
            end
            UPDATE: begin
                if (hit_q) begin
                    if (MODE == 0) begin
                        if (!visited_q[hidx_q]) begin
                            visited_d[hidx_q] = 1'b1;
                            count_d           = count_q + CNT_W'(1);
                        end
                    end else begin
                        visited_d[hidx_q] = !visited_q[hidx_q];
                        count_d = visited_q[hidx_q] ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
                    end
                end
                done_d  = (count_d == CNT_W'(NCUBES));
                state_d = done_d ? COMPLETE : IDLE;
            end
            COMPLETE: state_d = COMPLETE;
            default:  state_d = IDLE;
        endcase
        if (bus.level_clear) begin
            state_d   = IDLE;
            visited_d = '0;
            count_d   = '0;
            done_d    = 1'b0;
            ack_d     = 1'b0;
            fall_d    = 1'b0;
        end
    end

    assign bus.top_face      = top_q;
    assign bus.left_face     = left_q;
    assign bus.right_face    = right_q;
    assign bus.top_visited   = vis_q;
    assign bus.cube_idx      = idx_q;
    assign bus.land_ack      = ack_q;
    assign bus.fall          = fall_q;
    assign bus.visited_count = count_q;
    assign bus.level_done    = done_q;
endmodule

// File: doc/cube_field_generator.md
Name: cube_field_generator

Overview:
- Parametrised successor of the single-cube face generator. It renders a full Q*bert pyramid of isometric cubes, with ROWS rows and NCUBES = ROWS*(ROWS+1)/2 cubes, against the VGA pixel counters.
- Each cube carries a visited state. A landing FSM resolves Q*bert hops onto cubes, updates the visited states, flags falls off the pyramid, and signals level completion.
- It sits between the VGA timing counters and the pixel colour mux, and replaces per-cube instances.

Parameters:
- XHALF, 50, half-width in pixels of a cube top rhombus.
- YHALF, 30, half-height in pixels of a cube top rhombus.
- DEPTH, 60, vertical height in pixels of a side face.
- ROWS, 4, pyramid rows (1..7).
- MODE, 0, landing rule. 0: a hop sets visited and it stays set. 1: a hop toggles visited.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- x_cnt  in  11  pixel column.
- y_cnt  in  10  pixel row.
- x_offset  in  11  apex cube centre, X.
- y_offset  in  10  apex cube centre, Y.
- qbert_x  in  11  Q*bert landing point, X.
- qbert_y  in  10  Q*bert landing point, Y.
- qbert_land  in  1  one-cycle pulse: hop finished, position valid.
- level_clear  in  1  one-cycle pulse: reset the board for a new level.
- top_face  out  1  pixel lies on a top rhombus.
- left_face  out  1  pixel lies on a left side face.
- right_face  out  1  pixel lies on a right side face.
- top_visited  out  1  visited state of the cube owning the pixel (0 when no cube owns it).
- cube_idx  out  $clog2(NCUBES)  owning cube index, 0 when none.
- land_ack  out  1  pulse: landing resolved onto a cube.
- fall  out  1  pulse: landing matched no cube centre.
- visited_count  out  $clog2(NCUBES+1)  number of visited cubes.
- level_done  out  1  level: all cubes visited.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, all visited bits 0, count 0, FSM in IDLE, pipeline registers 0.
- Cube geometry:
  - Cube (r,c), with 0<=c<=r<ROWS, has index r*(r+1)/2+c.
  - Centre cx = x_offset + (2c-r)*XHALF; cy = y_offset + r*(YHALF+DEPTH).
  - Compute dx = x_cnt-cx and dy = y_cnt-cy as 13-bit signed values; no wrap is allowed.
- Face classification:
  - Top: |dx|*YHALF + |dy|*XHALF <= XHALF*YHALF.
  - Left: -XHALF <= dx < 0, with XHALF*YHALF - |dx|*YHALF < dy*XHALF <= XHALF*YHALF - |dx|*YHALF + DEPTH*XHALF.
  - Right: the same inequalities with 0 <= dx < XHALF.
  - The three faces of one cube are mutually exclusive; top is tested first.
- Pixel pipeline:
  - All cubes are evaluated in parallel.
  - Stage 1 registers the products. Stage 2 registers the face flags and priority encode.
  - The highest row index wins (front cube); within a row, the lowest c wins.
  - Output latency is exactly 2 clk cycles from x_cnt/y_cnt. It is fully pipelined, one pixel per cycle.
  - x_offset and y_offset are sampled each cycle, and a change takes effect with the same latency.
- Landing FSM states: IDLE, LOOKUP, UPDATE, COMPLETE.
  - IDLE: qbert_land=1 captures qbert_x and qbert_y, then goes to LOOKUP.
  - LOOKUP: compares the captured position with every cube centre for exact equality and latches the hit index, then goes to UPDATE.
  - UPDATE on a hit:
    - MODE 0: set the visited bit, and increment the count only if the bit was 0.
    - MODE 1: toggle the bit and increment or decrement the count.
    - land_ack=1 for one cycle. This is the cycle after LOOKUP, i.e. 2 cycles after the qbert_land cycle.
  - UPDATE on a miss: fall=1 for one cycle and no state change.
  - Next state after UPDATE: COMPLETE if the new count equals NCUBES, otherwise IDLE.
  - COMPLETE: level_done=1 and qbert_land is ignored.
- qbert_land arriving while in LOOKUP or UPDATE is dropped (no queueing).
- level_clear in any state:
  - Next cycle: all visited bits 0, count 0, level_done 0, state IDLE.
  - It has priority over a simultaneous qbert_land or UPDATE; no ack or fall is issued.
- top_visited reflects the visited bits registered at stage 2. A bit updated in UPDATE is visible on pixels entering stage 1 on the following cycle.
- Pixels outside every cube: all face flags 0, cube_idx 0, top_visited 0.

Test Plan:
- Defaults, offset (400,100), pixel (400,100) -> 2 cycles later top_face=1, cube_idx=0, left_face=0, right_face=0.
- Pixel (370,140) -> left_face=1, cube_idx=0. Pixel (430,140) -> right_face=1, cube_idx=0. Pixel (350,190) -> top_face=1, cube_idx=1. Pixel (0,0) -> all face flags 0.
- MODE 0: qbert_land at (450,190) -> land_ack exactly 2 cycles later, visited_count=1, pixel (450,190) shows top_visited=1. A repeat landing at (450,190) -> land_ack, count stays 1.
- qbert_land at (405,100) -> fall pulse 2 cycles later, count unchanged. A second qbert_land in the following cycle -> ignored, no second pulse.
- Land on all 10 cube centres -> level_done=1 after the 10th UPDATE. A further landing -> no ack. Then level_clear -> count 0, level_done 0 next cycle.
- MODE 1: land twice on cube 0 -> count goes 1 then 0. Assert reset low mid-LOOKUP -> immediate return to all-zero outputs and IDLE.
